// File: rtl/button_pulse_pkg.sv
// Shared FSM state type, default timing constants and counter sizing helper
// for the debounced button pulse generator.
package button_pulse_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_EN       = 1;
  localparam int DEF_REPEAT_DELAY    = 64;
  localparam int DEF_REPEAT_PERIOD   = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HELD,
    REPEAT,
    RELEASE
  } state_t;

  // Bits needed to hold values 0..max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; 2-cycle latency, no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // rst_n is active-high here: 1 clears both stages.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_pulse_gen.sv
// Debounces a raw button and emits one-cycle count-enable strobes (press + auto-repeat).
// Latency: press strobe DEBOUNCE_CYCLES+2 edges after first sample; no backpressure.
module button_pulse_gen
  import button_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o,
  output logic level_o
);

  // REPEAT_DELAY exceeds DEBOUNCE_CYCLES and bounds REPEAT_PERIOD, so it sizes cnt.
  localparam int CNT_W = cnt_width(REPEAT_DELAY);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(REPEAT_PERIOD - 1);
  localparam bit               REP_ON     = (REPEAT_EN != 0);

  logic             btn_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pulse_nxt;
  logic             level_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_i),
    .q     (btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pulse_o <= 1'b0;
      level_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pulse_o <= pulse_nxt;
      level_o <= level_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = ARM;
          cnt_nxt   = CNT_ONE;
        end
      end

      ARM: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      HELD: begin
        if (!btn_s) begin
          state_nxt = RELEASE;
          cnt_nxt   = CNT_ONE;
        end else if (REP_ON && (cnt == DELAY_LAST)) begin
          state_nxt = REPEAT;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else if (cnt != CNT_MAX) begin
          // Saturates only when repeat is off; otherwise DELAY_LAST is hit first.
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      REPEAT: begin
        if (!btn_s) begin
          state_nxt = RELEASE;
          cnt_nxt   = CNT_ONE;
        end else if (cnt == PER_LAST) begin
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      RELEASE: begin
        // A return to 1 is release bounce: stay pressed, restart the hold timer, no strobe.
        if (btn_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    level_nxt = (state_nxt == HELD) || (state_nxt == REPEAT) || (state_nxt == RELEASE);
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: directed scenarios plus random button runs against a run-length model.
module tb_button_pulse_gen;

  localparam int DEB    = 4;
  localparam int DELAY  = 16;
  localparam int PERIOD = 4;

  logic clk;
  logic rst_n;
  logic btn;
  logic pulse_r, level_r;
  logic pulse_n, level_n;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_PERIOD   (PERIOD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn),
    .pulse_o (pulse_r),
    .level_o (level_r)
  );

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_EN       (0),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_PERIOD   (PERIOD)
  ) dut_nr (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn),
    .pulse_o (pulse_n),
    .level_o (level_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: m1/m2 are the delay line; per-instance run-length bookkeeping.
  logic m1, m2;
  int   cyc;
  int   lv     [2];
  int   ones   [2];
  int   zeros  [2];
  int   anchor [2];
  int   ep     [2];
  int   rep    [2];
  logic prev_r, prev_n;

  int          seg_base;
  logic [63:0] mask_r, mask_n;
  int          lvl_cnt_r;
  logic [3:0]  cnt4;
  int          exp_cnt;
  logic [63:0] exp_mask;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input int i, input logic s);
    ep[i] = 0;
    if (lv[i] == 0) begin
      ones[i] = s ? ones[i] + 1 : 0;
      if (ones[i] == DEB + 1) begin
        lv[i] = 1; ep[i] = 1; anchor[i] = cyc; ones[i] = 0; zeros[i] = 0;
      end
    end else if (!s) begin
      zeros[i]++;
      if (zeros[i] == DEB + 1) begin
        lv[i] = 0; zeros[i] = 0; ones[i] = 0;
      end
    end else if (zeros[i] > 0) begin
      anchor[i] = cyc; zeros[i] = 0;
    end else if (rep[i] != 0 && (cyc - anchor[i]) >= DELAY &&
                 ((cyc - anchor[i] - DELAY) % PERIOD) == 0) begin
      ep[i] = 1;
    end
  endtask

  task automatic step(input logic b, input logic r);
    logic s;
    int   off;
    btn   = b;
    rst_n = r;
    @(posedge clk);
    #1;
    if (r) begin
      m1 = 1'b0; m2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
        lv[i] = 0; ones[i] = 0; zeros[i] = 0; ep[i] = 0;
      end
    end else begin
      s  = m2;
      m2 = m1;
      m1 = b;
      model_edge(0, s);
      model_edge(1, s);
    end
    check("pulse",       {63'd0, pulse_r}, 64'(ep[0]));
    check("level",       {63'd0, level_r}, 64'(lv[0]));
    check("pulse_norep", {63'd0, pulse_n}, 64'(ep[1]));
    check("level_norep", {63'd0, level_n}, 64'(lv[1]));
    check("no_adjacent", {63'd0, pulse_r & prev_r}, 64'd0);
    prev_r = pulse_r;
    prev_n = pulse_n;
    off = cyc - seg_base;
    if (off >= 0 && off < 64) begin
      if (pulse_r === 1'b1) mask_r[off] = 1'b1;
      if (pulse_n === 1'b1) mask_n[off] = 1'b1;
    end
    if (level_r === 1'b1) lvl_cnt_r++;
    if (pulse_n === 1'b1) cnt4 = cnt4 + 4'd1;
    if (ep[1] != 0) exp_cnt++;
    cyc++;
  endtask

  task automatic start_seg();
    seg_base  = cyc;
    mask_r    = '0;
    mask_n    = '0;
    lvl_cnt_r = 0;
  endtask

  initial begin
    logic b;
    int   len;
    cyc = 0; seg_base = 0; m1 = 0; m2 = 0;
    prev_r = 0; prev_n = 0; cnt4 = 0; exp_cnt = 0; lvl_cnt_r = 0;
    mask_r = '0; mask_n = '0;
    rep[0] = 1; rep[1] = 0;
    for (int i = 0; i < 2; i++) begin
      lv[i] = 0; ones[i] = 0; zeros[i] = 0; anchor[i] = 0; ep[i] = 0;
    end
    btn = 1'b0; rst_n = 1'b1;

    // Reset state
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    check("reset_pulse", {63'd0, pulse_r}, 64'd0);
    check("reset_level", {63'd0, level_r}, 64'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0);

    // Clean press held 40 cycles: press strobe then auto-repeat, release drops level at +6
    start_seg();
    for (int k = 0; k < 40; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0);
    exp_mask = '0;
    exp_mask[6] = 1'b1; exp_mask[22] = 1'b1; exp_mask[26] = 1'b1;
    exp_mask[30] = 1'b1; exp_mask[34] = 1'b1; exp_mask[38] = 1'b1;
    check("hold40_pulses", mask_r, exp_mask);
    exp_mask = '0;
    exp_mask[6] = 1'b1;
    check("hold40_pulses_norep", mask_n, exp_mask);
    check("hold40_level_cycles", 64'(lvl_cnt_r), 64'd40);

    // Press bounce 1,1,0,0,1,1,0,0 then a steady press
    start_seg();
    for (int k = 0; k < 8; k++) step(k[1] == 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0);
    exp_mask = '0;
    exp_mask[14] = 1'b1;
    check("bounce_pulses", mask_r, exp_mask);

    // Release bounce mid-hold keeps level up and never strobes
    start_seg();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0);
    exp_mask = '0;
    exp_mask[6] = 1'b1;
    check("rel_bounce_pulses", mask_r, exp_mask);
    check("rel_bounce_level_cycles", 64'(lvl_cnt_r), 64'd20);

    // Reset for one cycle during auto-repeat with the button still held
    start_seg();
    for (int k = 0; k < 25; k++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("midreset_pulse", {63'd0, pulse_r}, 64'd0);
    check("midreset_level", {63'd0, level_r}, 64'd0);
    for (int k = 0; k < 14; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0);
    exp_mask = '0;
    exp_mask[6] = 1'b1; exp_mask[22] = 1'b1; exp_mask[32] = 1'b1;
    check("midreset_pulses", mask_r, exp_mask);

    // Random button runs with occasional resets, checked cycle by cycle
    for (int k = 0; k < 150; k++) begin
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(15, 45);
      else len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) step(b, ($urandom_range(0, 199) == 0));
    end
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0);

    // Sixteen presses wrap a 4-bit counter driven by the strobe back to zero
    cnt4 = 4'd0;
    exp_cnt = 0;
    for (int p = 0; p < 16; p++) begin
      for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
      for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
    end
    check("cnt4_vs_model", 64'(cnt4), 64'(exp_cnt[3:0]));
    check("cnt4_wrapped", 64'(cnt4), 64'd0);
    check("press_count", 64'(exp_cnt), 64'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
